video_system_key_pio: RTL and testbench

// - Parametrised successor to the single-bit push-button input port: WIDTH-bit input PIO on the Avalon-MM bus.
// - Adds per-bit synchroniser, debounce filter, edge capture, interrupt mask and a level IRQ to the CPU.
// - Sits between the board pushbuttons (KEY[n:0]) and the Nios II data master.

---
 rtl/video_system_key_pio_if.sv | 18 +
 rtl/video_system_key_pio.sv | 136 +++++++++++++
 tb/tb_video_system_key_pio.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/video_system_key_pio_if.sv
// Avalon-MM slave bus for the key PIO: word address, select, active-low write strobe, data.
interface video_system_key_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/video_system_key_pio.sv
// Push-button input PIO: synchroniser, per-bit debounce, edge capture with W1C,
// interrupt mask and a registered level IRQ, all behind a 4-word Avalon-MM slave.
module video_system_key_pio #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  video_system_key_pio_if.slave avs,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_w;

  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] rise_w, fall_w, edge_w;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecapture_q, edgecapture_d;
  logic [WIDTH-1:0] w1c_w;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;

  // Synchroniser chain; the last stage is the only view of in_port the filter sees.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // A bit is accepted only after it has differed from stable for DEBOUNCE_CYCLES
  // consecutive cycles; agreement at any point restarts the count from zero.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_w[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync_w[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Edge is taken from the debounced value as it updates, so capture lands on
  // the same clock edge as the new stable value.
  assign rise_w = stable_d & ~stable_q;
  assign fall_w = ~stable_d & stable_q;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_w = rise_w;
      1:       edge_w = fall_w;
      default: edge_w = rise_w | fall_w;
    endcase
  end

  assign wr_en = avs.chipselect & ~avs.write_n;
  assign w1c_w = (wr_en && avs.address == ADDR_EDGE) ? avs.writedata[WIDTH-1:0] : '0;

  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_en && avs.address == ADDR_MASK) irqmask_d = avs.writedata[WIDTH-1:0];
  end

  // Clear first, then set: a capture in the same cycle as its W1C survives.
  assign edgecapture_d = (edgecapture_q & ~w1c_w) | edge_w;
  assign irq_d         = |(edgecapture_q & irqmask_q);

  always_comb begin
    readdata_d = '0;
    case (avs.address)
      ADDR_DATA: readdata_d = 32'(stable_q);
      ADDR_MASK: readdata_d = 32'(irqmask_q);
      ADDR_EDGE: readdata_d = 32'(edgecapture_q);
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q     <= '0;
      edgecapture_q <= '0;
      readdata_q    <= '0;
      irq_q         <= 1'b0;
    end else begin
      irqmask_q     <= irqmask_d;
      edgecapture_q <= edgecapture_d;
      readdata_q    <= readdata_d;
      irq_q         <= irq_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign irq          = irq_q;

  generate
    if (WIDTH < 32) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^avs.writedata[31:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_video_system_key_pio.sv
// Self-checking bench for video_system_key_pio (WIDTH=4, SYNC=2, DEBOUNCE=4, falling edge).
module tb_video_system_key_pio;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  video_system_key_pio_if bus ();

  video_system_key_pio #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE      (1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .avs    (bus.slave),
    .in_port(in_port),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  typedef struct {
    logic        cs;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[7];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a read address, queue the expectation, pop it once readdata has registered.
  task automatic read_chk(input logic [1:0] addr, input logic [31:0] exp, input string name);
    sb_t e;
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    sb_q.push_back('{exp: exp, name: name});
    @(negedge clk);
    bus.chipselect = 1'b0;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.name, bus.readdata, e.exp);
    end
  endtask

  task automatic write(input logic [1:0] addr, input logic [31:0] data, input logic cs);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = cs;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    in_port        = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // Reset held with keys idle-high, then exact DATA latency after release
    tick(3);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(5);
    read_chk(2'd0, 32'h0, "data_before_latency");
    read_chk(2'd0, 32'hF, "data_at_latency");
    read_chk(2'd3, 32'h0, "edge_after_rst");
    check("irq_after_rst", {31'd0, irq}, 32'h0);

    // Bounce on bit0: two short pulses must not pass the filter
    in_port = 4'hE; tick(2);
    in_port = 4'hF; tick(2);
    in_port = 4'hE;
    tick(4);
    read_chk(2'd0, 32'hF, "bounce_data_early");
    read_chk(2'd3, 32'h0, "bounce_edge_early");
    read_chk(2'd0, 32'hE, "bounce_data_fell");
    read_chk(2'd3, 32'h1, "bounce_edge_once");
    tick(6);
    read_chk(2'd3, 32'h1, "bounce_edge_hold");
    check("bounce_irq_unmasked", {31'd0, irq}, 32'h0);

    // Mask/IRQ timing on bit0
    write(2'd3, 32'h1, 1'b1);
    read_chk(2'd3, 32'h0, "w1c_bit0");
    write(2'd2, 32'h1, 1'b1);
    read_chk(2'd2, 32'h1, "mask_1");
    in_port = 4'hF; tick(8);
    read_chk(2'd0, 32'hF, "release_bit0");
    read_chk(2'd3, 32'h0, "rising_not_captured");
    in_port = 4'hE;
    tick(5);
    check("irq_before_capture", {31'd0, irq}, 32'h0);
    tick(1);
    check("irq_same_cycle_capture", {31'd0, irq}, 32'h0);
    tick(1);
    check("irq_rise", {31'd0, irq}, 32'h1);
    read_chk(2'd3, 32'h1, "edge_bit0_set");
    write(2'd3, 32'h1, 1'b1);
    check("irq_hold_after_w1c", {31'd0, irq}, 32'h1);
    tick(1);
    check("irq_fall", {31'd0, irq}, 32'h0);
    read_chk(2'd3, 32'h0, "edge_cleared");

    // Masked bit2 capture, then unmask
    in_port = 4'hA; tick(8);
    read_chk(2'd3, 32'h4, "edge_bit2");
    check("irq_masked", {31'd0, irq}, 32'h0);
    write(2'd2, 32'h5, 1'b1);
    check("irq_unmask_pre", {31'd0, irq}, 32'h0);
    tick(1);
    check("irq_unmask", {31'd0, irq}, 32'h1);
    write(2'd3, 32'h4, 1'b1);
    tick(1);
    check("irq_bit2_clr", {31'd0, irq}, 32'h0);

    // W1C on bit1 landing on the same edge as its capture: set wins
    in_port = 4'h8;
    tick(5);
    write(2'd3, 32'h2, 1'b1);
    read_chk(2'd3, 32'h2, "set_beats_w1c");
    read_chk(2'd0, 32'h8, "data_bit1_low");
    write(2'd3, 32'h2, 1'b1);
    read_chk(2'd3, 32'h0, "w1c_bit1_later");

    // Reset while bit3 is mid-debounce
    in_port = 4'hF; tick(8);
    read_chk(2'd0, 32'hF, "all_released");
    in_port = 4'h7;
    tick(4);
    reset_n = 1'b0;
    tick(2);
    check("midrst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    read_chk(2'd0, 32'h0, "midrst_data_cleared");
    tick(8);
    read_chk(2'd0, 32'h7, "midrst_redebounce");
    read_chk(2'd3, 32'h0, "midrst_no_edge");
    read_chk(2'd2, 32'h0, "midrst_mask_cleared");

    // Register-access vectors
    vecs[0] = '{cs: 1'b1, wr: 1'b1, addr: 2'd2, wdata: 32'hA,        exp: 32'hA, name: "mask_a"};
    vecs[1] = '{cs: 1'b1, wr: 1'b1, addr: 2'd2, wdata: 32'hFFFFFFFF, exp: 32'hF, name: "mask_width"};
    vecs[2] = '{cs: 1'b0, wr: 1'b1, addr: 2'd2, wdata: 32'h5,        exp: 32'hF, name: "mask_no_cs"};
    vecs[3] = '{cs: 1'b1, wr: 1'b1, addr: 2'd0, wdata: 32'hFFFFFFF0, exp: 32'h7, name: "data_ro"};
    vecs[4] = '{cs: 1'b1, wr: 1'b1, addr: 2'd1, wdata: 32'hFFFFFFFF, exp: 32'h0, name: "addr1_zero"};
    vecs[5] = '{cs: 1'b1, wr: 1'b1, addr: 2'd3, wdata: 32'hF,        exp: 32'h0, name: "edge_w1c_empty"};
    vecs[6] = '{cs: 1'b1, wr: 1'b1, addr: 2'd2, wdata: 32'h0,        exp: 32'h0, name: "mask_clr"};
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].wr) write(vecs[v].addr, vecs[v].wdata, vecs[v].cs);
      read_chk(vecs[v].addr, vecs[v].exp, vecs[v].name);
    end
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
